// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
// Sequencing controller for a multi-cycle MIPS datapath (shared memory, IR, PC,
// register file, ALU). Steps each instruction from FETCH through writeback, one
// state per cycle. Memory states wait for mem_ready and are guarded by a
// watchdog. Unsupported opcodes and memory timeouts park the FSM in HALT until
// reset.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   run               1 = may start a new fetch, 0 = hold in FETCH
//   op, funct         IR[31:26], IR[5:0]
//   mem_ready         memory access completes this cycle
//   pc_write, pc_write_cond, pc_source      PC update control
//   i_or_d, mem_read, mem_write, ir_write   memory / IR control
//   reg_dst, mem_to_reg, reg_write          register file control
//   alu_src_a, alu_src_b, alu_op            ALU control
//   state             current state code (debug)
//   halted            FSM is in HALT
//   illegal_op        sticky: HALT entered on unsupported opcode/funct
//   bus_error         sticky: HALT entered on memory timeout
//   instr_count       retired instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_source,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [3:0]  state,
  output logic        halted,
  output logic        illegal_op,
  output logic        bus_error,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13,
    S_HALT      = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  state_t           state_q;
  state_t           decode_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;

  // Watchdog fires only when the counter is exhausted and memory is still
  // not ready; a late mem_ready on the final cycle still completes the access.
  assign timeout = (wait_cnt == TIMEOUT_CNT) && !mem_ready;

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // paths that skip the assignment infer a latch.
  always_comb begin
    decode_next = S_HALT;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_JR)
          decode_next = S_JR;
        else if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})
          decode_next = S_EXECUTE;
      end
      OP_LW, OP_SW:                      decode_next = S_MEM_ADDR;
      OP_BEQ:                            decode_next = S_BRANCH;
      OP_J:                              decode_next = S_JUMP;
      OP_JAL:                            decode_next = S_JAL;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: decode_next = S_IMM_EXEC;
      default:                           decode_next = S_HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      wait_cnt    <= '0;
      instr_count <= '0;
      illegal_op  <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!run) begin
            wait_cnt <= '0;  // counting restarts when run is granted
          end else if (mem_ready) begin
            state_q <= S_DECODE;
          end else if (timeout) begin
            state_q   <= S_HALT;
            bus_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          state_q <= decode_next;
          if (decode_next == S_HALT) illegal_op <= 1'b1;
        end
        S_MEM_ADDR: begin
          wait_cnt <= '0;
          state_q  <= (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          if (mem_ready) begin
            state_q <= S_MEM_WB;
          end else if (timeout) begin
            state_q   <= S_HALT;
            bus_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_MEM_WRITE: begin
          if (mem_ready) begin
            state_q     <= S_FETCH;
            wait_cnt    <= '0;
            instr_count <= instr_count + 32'd1;
          end else if (timeout) begin
            state_q   <= S_HALT;
            bus_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_EXECUTE:  state_q <= S_ALU_WB;
        S_IMM_EXEC: state_q <= S_IMM_WB;
        S_MEM_WB, S_ALU_WB, S_IMM_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: begin
          state_q     <= S_FETCH;
          wait_cnt    <= '0;
          instr_count <= instr_count + 32'd1;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_HALT;  // unused encoding: park safely
      endcase
    end
  end

  assign state  = state_q;
  assign halted = (state_q == S_HALT);

  // Strobes are decoded from the state register plus the same-cycle handshake
  // inputs (ir_write/pc_write must coincide with mem_ready), so they cannot be
  // registered. Gating with rst_n keeps every strobe low while reset is held.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          if (run) begin
            mem_read = 1'b1;
            if (mem_ready) begin
              ir_write  = 1'b1;
              pc_write  = 1'b1;
              alu_src_b = 2'b01;
            end
          end
        end
        S_DECODE:   alu_src_b = 2'b11;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end
        S_IMM_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
        end
        S_IMM_WB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_JAL: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        S_JR: begin
          pc_write  = 1'b1;
          pc_source = 2'b11;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Directed cycle-by-cycle stimulus for the multi-cycle MIPS controller. Each
// stimulus step pushes the hand-derived expected outputs for that cycle into a
// scoreboard queue; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        mem_ready;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  pc_source;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [3:0]  state;
  logic        halted;
  logic        illegal_op;
  logic        bus_error;
  logic [31:0] instr_count;

  multicycle_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .op(op), .funct(funct),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .halted(halted),
    .illegal_op(illegal_op), .bus_error(bus_error), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    ctrl_t       c;
    logic [2:0]  flags;  // {halted, illegal_op, bus_error}
    logic [31:0] cnt;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  ctrl_t act_c;

  assign act_c = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                  ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

  // Hand-derived control words, one per state (and per handshake outcome)
  ctrl_t k_zero, k_fetch_wait, k_fetch_hit, k_decode, k_mem_addr, k_mem_rd;
  ctrl_t k_mem_wb, k_mem_wr, k_exec, k_alu_wb, k_imm_exec, k_imm_wb;
  ctrl_t k_branch, k_jump, k_jal, k_jr;

  task automatic init_consts();
    k_zero = '0;
    k_fetch_wait = '0; k_fetch_wait.mem_read = 1'b1;
    k_fetch_hit  = k_fetch_wait;
    k_fetch_hit.ir_write = 1'b1; k_fetch_hit.pc_write = 1'b1; k_fetch_hit.alu_src_b = 2'b01;
    k_decode = '0; k_decode.alu_src_b = 2'b11;
    k_mem_addr = '0; k_mem_addr.alu_src_a = 1'b1; k_mem_addr.alu_src_b = 2'b10;
    k_mem_rd = '0; k_mem_rd.mem_read = 1'b1; k_mem_rd.i_or_d = 1'b1;
    k_mem_wb = '0; k_mem_wb.reg_write = 1'b1; k_mem_wb.mem_to_reg = 2'b01;
    k_mem_wr = '0; k_mem_wr.mem_write = 1'b1; k_mem_wr.i_or_d = 1'b1;
    k_exec = '0; k_exec.alu_src_a = 1'b1; k_exec.alu_op = 2'b10;
    k_alu_wb = '0; k_alu_wb.reg_write = 1'b1; k_alu_wb.reg_dst = 2'b01;
    k_imm_exec = '0; k_imm_exec.alu_src_a = 1'b1; k_imm_exec.alu_src_b = 2'b10;
    k_imm_exec.alu_op = 2'b11;
    k_imm_wb = '0; k_imm_wb.reg_write = 1'b1;
    k_branch = '0; k_branch.alu_src_a = 1'b1; k_branch.alu_op = 2'b01;
    k_branch.pc_write_cond = 1'b1; k_branch.pc_source = 2'b01;
    k_jump = '0; k_jump.pc_write = 1'b1; k_jump.pc_source = 2'b10;
    k_jal = k_jump; k_jal.reg_write = 1'b1; k_jal.reg_dst = 2'b10; k_jal.mem_to_reg = 2'b10;
    k_jr = '0; k_jr.pc_write = 1'b1; k_jr.pc_source = 2'b11;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, queue the expected outputs for this cycle,
  // then advance to just after the next rising edge.
  task automatic step(input string tag, input logic r, input logic mr,
                      input logic [3:0] st, input ctrl_t c,
                      input logic [2:0] fl, input logic [31:0] cnt);
    exp_t e;
    run       = r;
    mem_ready = mr;
    e.tag = tag; e.st = st; e.c = c; e.flags = fl; e.cnt = cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [5:0] o, input logic [5:0] f);
    op    = o;
    funct = f;
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the queue
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({e.tag, ".state"}, 64'(state), 64'(e.st));
      check({e.tag, ".ctrl"},  64'(act_c), 64'(e.c));
      check({e.tag, ".flags"}, 64'({halted, illegal_op, bus_error}), 64'(e.flags));
      check({e.tag, ".count"}, 64'(instr_count), 64'(e.cnt));
    end
  end

  initial begin : sim_bound
    #200000;
    $display("FAIL sim_timeout: simulation did not finish within time bound");
    $fatal(1, "time bound expired");
  end

  initial begin : stimulus
    init_consts();
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; op = '0; funct = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: run=0 keeps FETCH quiet
    step("idle", 0, 1, 4'd0, k_zero, 3'b000, 0);

    // add: 0,1,6,7
    load_ir(6'h00, 6'h20);
    step("add.f", 1, 1, 4'd0, k_fetch_hit, 3'b000, 0);
    step("add.d", 1, 0, 4'd1, k_decode,    3'b000, 0);
    step("add.e", 1, 0, 4'd6, k_exec,      3'b000, 0);
    step("add.w", 1, 0, 4'd7, k_alu_wb,    3'b000, 0);

    // lw with three wait cycles: 0,1,2,3,3,3,3,4
    load_ir(6'h23, 6'h00);
    step("lw.f",  1, 1, 4'd0, k_fetch_hit, 3'b000, 1);
    step("lw.d",  1, 0, 4'd1, k_decode,    3'b000, 1);
    step("lw.a",  1, 0, 4'd2, k_mem_addr,  3'b000, 1);
    for (int i = 0; i < 3; i++)
      step("lw.rw", 1, 0, 4'd3, k_mem_rd, 3'b000, 1);
    step("lw.r",  1, 1, 4'd3, k_mem_rd,    3'b000, 1);
    step("lw.wb", 1, 0, 4'd4, k_mem_wb,    3'b000, 1);

    // lw abandoned by reset in MEM_READ
    step("lw2.f", 1, 1, 4'd0, k_fetch_hit, 3'b000, 2);
    step("lw2.d", 1, 0, 4'd1, k_decode,    3'b000, 2);
    step("lw2.a", 1, 0, 4'd2, k_mem_addr,  3'b000, 2);
    run = 1'b1; mem_ready = 1'b0;
    begin
      exp_t e;
      e.tag = "lw2.r"; e.st = 4'd3; e.c = k_mem_rd; e.flags = 3'b000; e.cnt = 2;
      sb_q.push_back(e);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst.state", 64'(state), 64'd0);
    check("rst.ctrl",  64'(act_c), 64'(k_zero));
    check("rst.count", 64'(instr_count), 64'd0);
    check("rst.flags", 64'({halted, illegal_op, bus_error}), 64'd0);
    @(posedge clk);
    #1;
    check("rst.hold.ctrl", 64'(act_c), 64'(k_zero));
    rst_n = 1'b1;
    step("rst.fetch", 1, 0, 4'd0, k_fetch_wait, 3'b000, 0);

    // jal: 0,1,12
    load_ir(6'h03, 6'h00);
    step("jal.f", 1, 1, 4'd0,  k_fetch_hit, 3'b000, 0);
    step("jal.d", 1, 0, 4'd1,  k_decode,    3'b000, 0);
    step("jal.j", 1, 0, 4'd12, k_jal,       3'b000, 0);

    // beq: 0,1,8
    load_ir(6'h04, 6'h00);
    step("beq.f", 1, 1, 4'd0, k_fetch_hit, 3'b000, 1);
    step("beq.d", 1, 0, 4'd1, k_decode,    3'b000, 1);
    step("beq.b", 1, 0, 4'd8, k_branch,    3'b000, 1);

    // j: 0,1,9
    load_ir(6'h02, 6'h00);
    step("j.f", 1, 1, 4'd0, k_fetch_hit, 3'b000, 2);
    step("j.d", 1, 0, 4'd1, k_decode,    3'b000, 2);
    step("j.j", 1, 0, 4'd9, k_jump,      3'b000, 2);

    // jr: 0,1,13
    load_ir(6'h00, 6'h08);
    step("jr.f", 1, 1, 4'd0,  k_fetch_hit, 3'b000, 3);
    step("jr.d", 1, 0, 4'd1,  k_decode,    3'b000, 3);
    step("jr.j", 1, 0, 4'd13, k_jr,        3'b000, 3);

    // addi: 0,1,10,11
    load_ir(6'h08, 6'h00);
    step("addi.f", 1, 1, 4'd0,  k_fetch_hit, 3'b000, 4);
    step("addi.d", 1, 0, 4'd1,  k_decode,    3'b000, 4);
    step("addi.e", 1, 0, 4'd10, k_imm_exec,  3'b000, 4);
    step("addi.w", 1, 0, 4'd11, k_imm_wb,    3'b000, 4);

    // sw with immediate ready: 0,1,2,5
    load_ir(6'h2B, 6'h00);
    step("sw.f", 1, 1, 4'd0, k_fetch_hit, 3'b000, 5);
    step("sw.d", 1, 0, 4'd1, k_decode,    3'b000, 5);
    step("sw.a", 1, 0, 4'd2, k_mem_addr,  3'b000, 5);
    step("sw.w", 1, 1, 4'd5, k_mem_wr,    3'b000, 5);

    // lw: ready arrives on the last allowed cycle (counter == 15) and wins
    load_ir(6'h23, 6'h00);
    step("lwb.f", 1, 1, 4'd0, k_fetch_hit, 3'b000, 6);
    step("lwb.d", 1, 0, 4'd1, k_decode,    3'b000, 6);
    step("lwb.a", 1, 0, 4'd2, k_mem_addr,  3'b000, 6);
    for (int i = 0; i < 15; i++)
      step("lwb.rw", 1, 0, 4'd3, k_mem_rd, 3'b000, 6);
    step("lwb.r",  1, 1, 4'd3, k_mem_rd,    3'b000, 6);
    step("lwb.wb", 1, 0, 4'd4, k_mem_wb,    3'b000, 6);

    // run=0 holds FETCH; stray mem_ready ignored
    load_ir(6'h3F, 6'h00);
    step("hold", 0, 1, 4'd0, k_zero, 3'b000, 7);
    step("hold", 0, 1, 4'd0, k_zero, 3'b000, 7);

    // Illegal opcode 0x3F: DECODE then HALT for 20 cycles
    step("ill.f", 1, 1, 4'd0, k_fetch_hit, 3'b000, 7);
    step("ill.d", 1, 0, 4'd1, k_decode,    3'b000, 7);
    for (int i = 0; i < 20; i++)
      step("ill.h", 1, 1, 4'd14, k_zero, 3'b110, 7);

    // Reset out of HALT, then sw that never gets mem_ready
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    load_ir(6'h2B, 6'h00);
    step("swt.f", 1, 1, 4'd0, k_fetch_hit, 3'b000, 0);
    step("swt.d", 1, 0, 4'd1, k_decode,    3'b000, 0);
    step("swt.a", 1, 0, 4'd2, k_mem_addr,  3'b000, 0);
    for (int i = 0; i < 16; i++)
      step("swt.w", 1, 0, 4'd5, k_mem_wr, 3'b000, 0);
    for (int i = 0; i < 3; i++)
      step("swt.h", 1, 1, 4'd14, k_zero, 3'b101, 0);

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
